// File: rtl/sub_bytes_seq_pkg.sv
// Shared AES definitions: state geometry, SubBytes FSM encoding and the
// FIPS-197 forward S-box table used by the s_box lookup.
package sub_bytes_seq_pkg;

  localparam int unsigned AES_STATE_BYTES = 16;

  typedef logic [8*AES_STATE_BYTES-1:0] aes_state_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } sub_bytes_state_e;

  // Entry 0x00 sits in the most significant byte, one table row per line.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox_lookup(input logic [7:0] a);
    return SBOX_TABLE[2047 - 8*int'(a) -: 8];
  endfunction

endpackage

// File: rtl/sub_bytes_seq_s_box.sv
// Forward AES S-box, purely combinational. The clk port is kept so the
// instance matches existing registered variants; it is not used here.
module s_box
  import sub_bytes_seq_pkg::*;
(
  input  logic       clk,
  input  logic [7:0] value,
  output logic [7:0] result
);

  logic clk_unused;
  assign clk_unused = clk;

  always_comb begin
    result = sbox_lookup(value);
  end

endmodule

// File: rtl/sub_bytes_seq.sv
// Byte-serial AES SubBytes: accepts a state, substitutes one byte per cycle
// (two with SUB_BYTES_DUAL_LANE_EN defined) and holds the result until taken.
module sub_bytes_seq
  import sub_bytes_seq_pkg::*;
#(
  parameter int unsigned NUM_BYTES = AES_STATE_BYTES
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [8*NUM_BYTES-1:0] in_state,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [8*NUM_BYTES-1:0] out_state,
  output logic                   busy
);

  localparam int unsigned CW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
`ifdef SUB_BYTES_DUAL_LANE_EN
  localparam int unsigned LANES = 2;
`else
  localparam int unsigned LANES = 1;
`endif
  localparam logic [CW-1:0] LAST = CW'(NUM_BYTES - LANES);
  localparam logic [CW-1:0] STEP = CW'(LANES);

  sub_bytes_state_e       state;
  sub_bytes_state_e       state_next;
  logic [CW-1:0]          cnt;
  logic [8*NUM_BYTES-1:0] data;
  logic [7:0]             lane_in  [LANES];
  logic [7:0]             lane_out [LANES];

  // Lane l works on byte cnt+l; byte 0 is the most significant byte.
  always_comb begin
    for (int unsigned l = 0; l < LANES; l++) begin
      lane_in[l] = '0;
      for (int unsigned i = 0; i < NUM_BYTES; i++) begin
        if (cnt + CW'(l) == CW'(i)) begin
          lane_in[l] = data[8*(NUM_BYTES-i)-1 -: 8];
        end
      end
    end
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    s_box u_s_box (
      .clk    (clk),
      .value  (lane_in[l]),
      .result (lane_out[l])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)     state_next = RUN;
      RUN:     if (cnt == LAST)  state_next = DONE;
      DONE:    if (out_ready)    state_next = IDLE;
      default:                   state_next = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state == RUN);
  end

  // cnt parks on LAST through DONE and is re-zeroed by the next accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data <= '0;
      cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            data <= in_state;
            cnt  <= '0;
          end
        end
        RUN: begin
          for (int unsigned l = 0; l < LANES; l++) begin
            for (int unsigned i = 0; i < NUM_BYTES; i++) begin
              if (cnt + CW'(l) == CW'(i)) begin
                data[8*(NUM_BYTES-i)-1 -: 8] <= lane_out[l];
              end
            end
          end
          if (cnt != LAST) begin
            cnt <= cnt + STEP;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_state = data;

endmodule

// File: tb/tb_sub_bytes_seq.sv
// Scoreboard bench for sub_bytes_seq; reference S-box is derived from the
// GF(2^8) inverse plus the AES affine transform.
module tb_sub_bytes_seq;
  import sub_bytes_seq_pkg::*;

  localparam int unsigned NB = 16;
`ifdef SUB_BYTES_DUAL_LANE_EN
  localparam int LAT = 8;
`else
  localparam int LAT = 16;
`endif
  localparam int PERIOD = LAT + 2;
  localparam int TMO    = 200;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  aes_state_t in_state;
  logic       out_valid;
  logic       out_ready;
  aes_state_t out_state;
  logic       busy;

  sub_bytes_seq #(.NUM_BYTES(NB)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_state  (in_state),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_state (out_state),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] sbox_ref [256];
  aes_state_t exp_q [$];
  int         acc_q [$];
  int         tests = 0;
  int         fails = 0;
  bit         ov_prev = 1'b0;
  bit         tx_done = 1'b0;

  task automatic check_int(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_st(input string name, input aes_state_t act, input aes_state_t exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = '0;
    logic [7:0] x = a;
    logic [7:0] y = b;
    for (int k = 0; k < 8; k++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    return 8'((b << n) | (b >> (8 - n)));
  endfunction

  function automatic aes_state_t ref_sub(input aes_state_t s);
    aes_state_t r = '0;
    for (int k = 0; k < 16; k++) r[127-8*k -: 8] = sbox_ref[s[127-8*k -: 8]];
    return r;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check_int({tag, "_in_ready"}, int'(in_ready), 1);
    check_int({tag, "_out_valid"}, int'(out_valid), 0);
    check_int({tag, "_busy"}, int'(busy), 0);
    check_st({tag, "_out_state"}, out_state, '0);
  endtask

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic send(input aes_state_t v, output int acc);
    int n = 0;
    in_state = v;
    in_valid = 1'b1;
    while (!in_ready && n < TMO) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: in_ready stayed 0 for %0d cycles, required 1", TMO);
      acc = -1;
      in_valid = 1'b0;
    end else begin
      acc = cyc + 1;
      exp_q.push_back(ref_sub(v));
      acc_q.push_back(acc);
      @(negedge clk);
      check_int("busy_run", int'(busy), 1);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < TMO) begin
      @(negedge clk);
      n++;
    end
    check_int("drain_pending", exp_q.size(), 0);
    @(negedge clk);
  endtask

  // Monitor: latency on each out_valid rise, data on every valid cycle.
  always @(negedge clk) begin : monitor
    int a;
    #1;
    if (rst) begin
      ov_prev = 1'b0;
    end else begin
      if (out_valid && !ov_prev) begin
        if (acc_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL spurious_out_valid: got out_valid=1 required 0 (no pending accept)");
        end else begin
          a = acc_q.pop_front();
          check_int("latency", cyc - a, LAT);
        end
        check_int("busy_done", int'(busy), 0);
        check_int("in_ready_done", int'(in_ready), 0);
      end
      if (out_valid && exp_q.size() != 0) begin
        check_st("out_state", out_state, exp_q[0]);
        if (out_ready) void'(exp_q.pop_front());
      end
      ov_prev = out_valid;
    end
  end

  initial begin : watchdog
    #2_000_000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

  initial begin : driver
    int acc;
    int prev;
    aes_state_t v;
    logic [7:0] inv;

    for (int x = 0; x < 256; x++) begin
      inv = '0;
      for (int y = 1; y < 256; y++) if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      sbox_ref[x] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    end

    rst = 1'b1;
    in_valid = 1'b0;
    in_state = '0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1 check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    send(128'h193de3bea0f4e22b9ac68d2ae9f84808, acc);
    in_valid = 1'b0;
    drain();
    check_st("fips197_ref", ref_sub(128'h193de3bea0f4e22b9ac68d2ae9f84808),
             128'hd42711aee0bf98f1b8b45de51e415230);

    send('0, acc);          in_valid = 1'b0; drain();
    send('1, acc);          in_valid = 1'b0; drain();
    send({16{8'h53}}, acc); in_valid = 1'b0; drain();

    // Back-pressure: result must hold and in_valid must be ignored.
    out_ready = 1'b0;
    send({$urandom, $urandom, $urandom, $urandom}, acc);
    in_valid = 1'b0;
    for (int n = 0; n < TMO && !out_valid; n++) @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      in_state = {$urandom, $urandom, $urandom, $urandom};
      in_valid = (i == 5);
      #2;
      check_int("bp_out_valid", int'(out_valid), 1);
      check_int("bp_in_ready", int'(in_ready), 0);
    end
    in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    #2;
    check_int("release_in_ready", int'(in_ready), 1);
    check_int("release_out_valid", int'(out_valid), 0);
    check_int("release_pending", exp_q.size(), 0);

    // Reset while byte 7 is being substituted.
    @(negedge clk);
    send({$urandom, $urandom, $urandom, $urandom}, acc);
    in_valid = 1'b0;
    repeat (7) @(negedge clk);
    check_int("busy_before_rst", int'(busy), 1);
    #2;
    rst = 1'b1;
    exp_q.delete();
    acc_q.delete();
    #1 check_reset_outputs("mid_run_reset");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send({$urandom, $urandom, $urandom, $urandom}, acc);
    in_valid = 1'b0;
    drain();

    // Random vectors with random gaps and random downstream stalls.
    fork
      begin
        for (int n = 0; n < 3000 && !tx_done; n++) begin
          @(negedge clk);
          out_ready = 1'($urandom_range(0, 1));
        end
      end
      begin
        for (int j = 0; j < 8; j++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          send({$urandom, $urandom, $urandom, $urandom}, acc);
          in_valid = 1'b0;
        end
        tx_done = 1'b1;
      end
    join
    @(negedge clk);
    out_ready = 1'b1;
    drain();

    // Back-to-back sweep covering every byte value, in_valid held high.
    prev = -1;
    for (int j = 0; j < 16; j++) begin
      for (int k = 0; k < 16; k++) v[127-8*k -: 8] = 8'(16*j + k);
      send(v, acc);
      if (j > 0) check_int("b2b_period", acc - prev, PERIOD);
      prev = acc;
    end
    in_valid = 1'b0;
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
